// File: rtl/ccip_host_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : ccip_host_mem_responder_if
// Purpose  : CCI-P c0/c1 request, response and status bundle between AFU and responder
// Revision : 1.0  initial release
// ============================================================================
interface ccip_host_mem_responder_if;
    logic         c0_req_valid;
    logic [41:0]  c0_req_addr;
    logic [15:0]  c0_req_mdata;
    logic         c1_req_valid;
    logic [41:0]  c1_req_addr;
    logic [15:0]  c1_req_mdata;
    logic [511:0] c1_req_data;
    logic         c0TxAlmFull;
    logic         c1TxAlmFull;
    logic         c0_rsp_valid;
    logic [15:0]  c0_rsp_mdata;
    logic [511:0] c0_rsp_data;
    logic         c1_rsp_valid;
    logic [15:0]  c1_rsp_mdata;
    logic         err_overflow;
    logic         init_done;

    modport master (
        output c0_req_valid, c0_req_addr, c0_req_mdata,
        output c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
        input  c0TxAlmFull, c1TxAlmFull,
        input  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        input  c1_rsp_valid, c1_rsp_mdata,
        input  err_overflow, init_done
    );

    modport slave (
        input  c0_req_valid, c0_req_addr, c0_req_mdata,
        input  c1_req_valid, c1_req_addr, c1_req_mdata, c1_req_data,
        output c0TxAlmFull, c1TxAlmFull,
        output c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
        output c1_rsp_valid, c1_rsp_mdata,
        output err_overflow, init_done
    );
endinterface
`default_nettype wire

// File: rtl/ccip_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : ccip_host_mem_responder
// Purpose  : FIU-side CCI-P responder servicing c0 reads / c1 writes from a line memory
// Revision : 1.0  initial release
// ============================================================================
module ccip_host_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH     = 16,
    parameter int ALMFULL_SLACK  = 8,
    parameter int RD_LATENCY     = 4
) (
    input  wire logic                pClk,
    input  wire logic                pck_cp2af_softReset_n,
    ccip_host_mem_responder_if.slave bus
);
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
    localparam logic [c_CNT_W-1:0]        c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]        c_ALM_THRESH = c_CNT_W'(FIFO_DEPTH - ALMFULL_SLACK);
    localparam logic [MEM_ADDR_WIDTH-1:0] c_LAST_LINE  = '1;

    typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                    r_state, w_state_nxt;
    logic                      r_rst_n_sync;
    logic [MEM_ADDR_WIDTH-1:0] r_init_idx;

    logic [MEM_ADDR_WIDTH-1:0] r_c0_idx_q   [FIFO_DEPTH];
    logic [15:0]               r_c0_mdata_q [FIFO_DEPTH];
    logic [MEM_ADDR_WIDTH-1:0] r_c1_idx_q   [FIFO_DEPTH];
    logic [15:0]               r_c1_mdata_q [FIFO_DEPTH];
    logic [511:0]              r_c1_data_q  [FIFO_DEPTH];
    logic [c_PTR_W-1:0]        r_c0_wptr, r_c0_rptr, r_c1_wptr, r_c1_rptr;
    logic [c_CNT_W-1:0]        r_c0_cnt, r_c1_cnt, w_c0_cnt_nxt, w_c1_cnt_nxt;
    logic                      w_c0_push, w_c1_push, w_c0_pop, w_c1_pop, w_ovf;

    logic [511:0]              r_mem [c_MEM_DEPTH];
    logic                      w_mem_we;
    logic [MEM_ADDR_WIDTH-1:0] w_mem_widx, w_c0_idx, w_c1_idx;
    logic [511:0]              w_mem_wdata, w_rd_data, w_c1_data;
    logic [15:0]               w_c0_mdata, w_c1_mdata;

    logic [RD_LATENCY-1:0]     r_rd_vld;
    logic [15:0]               r_rd_mdata [RD_LATENCY];
    logic [511:0]              r_rd_data  [RD_LATENCY];
    logic                      r_c1_rsp_vld, r_c0_almfull, r_c1_almfull, r_err;
    logic [15:0]               r_c1_rsp_mdata;
    logic                      w_unused_addr_bits;

    // Asynchronous assert, synchronous release of the internal reset
    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) r_rst_n_sync <= 1'b0;
        else                        r_rst_n_sync <= 1'b1;
    end

    always_ff @(posedge pClk or negedge r_rst_n_sync) begin
        if (!r_rst_n_sync) begin
            r_state    <= ST_INIT;
            r_init_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_INIT) r_init_idx <= r_init_idx + MEM_ADDR_WIDTH'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_init_idx == c_LAST_LINE) w_state_nxt = ST_RUN;
            default: w_state_nxt = r_state;
        endcase
    end

    // A push against a full FIFO is dropped even if that FIFO pops in the same cycle
    assign w_c0_push    = bus.c0_req_valid && (r_c0_cnt != c_FULL);
    assign w_c1_push    = bus.c1_req_valid && (r_c1_cnt != c_FULL);
    assign w_ovf        = (bus.c0_req_valid && (r_c0_cnt == c_FULL)) ||
                          (bus.c1_req_valid && (r_c1_cnt == c_FULL));
    assign w_c0_pop     = (r_state == ST_RUN) && (r_c0_cnt != '0);
    assign w_c1_pop     = (r_state == ST_RUN) && (r_c1_cnt != '0);
    assign w_c0_cnt_nxt = r_c0_cnt + c_CNT_W'(w_c0_push) - c_CNT_W'(w_c0_pop);
    assign w_c1_cnt_nxt = r_c1_cnt + c_CNT_W'(w_c1_push) - c_CNT_W'(w_c1_pop);

    assign w_c0_idx   = r_c0_idx_q[r_c0_rptr];
    assign w_c0_mdata = r_c0_mdata_q[r_c0_rptr];
    assign w_c1_idx   = r_c1_idx_q[r_c1_rptr];
    assign w_c1_mdata = r_c1_mdata_q[r_c1_rptr];
    assign w_c1_data  = r_c1_data_q[r_c1_rptr];

    assign w_unused_addr_bits = ^{bus.c0_req_addr[41:MEM_ADDR_WIDTH], bus.c1_req_addr[41:MEM_ADDR_WIDTH]};

    always_ff @(posedge pClk) begin
        if (w_c0_push) begin
            r_c0_idx_q[r_c0_wptr]   <= bus.c0_req_addr[MEM_ADDR_WIDTH-1:0];
            r_c0_mdata_q[r_c0_wptr] <= bus.c0_req_mdata;
        end
        if (w_c1_push) begin
            r_c1_idx_q[r_c1_wptr]   <= bus.c1_req_addr[MEM_ADDR_WIDTH-1:0];
            r_c1_mdata_q[r_c1_wptr] <= bus.c1_req_mdata;
            r_c1_data_q[r_c1_wptr]  <= bus.c1_req_data;
        end
    end

    // Single write port: the init sweep owns it until RUN, then c1 pops
    assign w_mem_we    = (r_state == ST_INIT) || w_c1_pop;
    assign w_mem_widx  = (r_state == ST_INIT) ? r_init_idx : w_c1_idx;
    assign w_mem_wdata = (r_state == ST_INIT) ? '0 : w_c1_data;
    assign w_rd_data   = (w_c1_pop && (w_c1_idx == w_c0_idx)) ? w_c1_data : r_mem[w_c0_idx];

    always_ff @(posedge pClk) begin
        if (w_mem_we) r_mem[w_mem_widx] <= w_mem_wdata;
    end

    always_ff @(posedge pClk or negedge r_rst_n_sync) begin
        if (!r_rst_n_sync) begin
            r_c0_wptr      <= '0;
            r_c0_rptr      <= '0;
            r_c0_cnt       <= '0;
            r_c1_wptr      <= '0;
            r_c1_rptr      <= '0;
            r_c1_cnt       <= '0;
            r_c0_almfull   <= 1'b1;
            r_c1_almfull   <= 1'b1;
            r_err          <= 1'b0;
            r_c1_rsp_vld   <= 1'b0;
            r_c1_rsp_mdata <= '0;
            r_rd_vld       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_rd_mdata[i] <= '0;
                r_rd_data[i]  <= '0;
            end
        end else begin
            if (w_c0_push) r_c0_wptr <= r_c0_wptr + c_PTR_W'(1);
            if (w_c0_pop)  r_c0_rptr <= r_c0_rptr + c_PTR_W'(1);
            if (w_c1_push) r_c1_wptr <= r_c1_wptr + c_PTR_W'(1);
            if (w_c1_pop)  r_c1_rptr <= r_c1_rptr + c_PTR_W'(1);
            r_c0_cnt       <= w_c0_cnt_nxt;
            r_c1_cnt       <= w_c1_cnt_nxt;
            r_c0_almfull   <= (w_state_nxt == ST_RUN) ? (w_c0_cnt_nxt >= c_ALM_THRESH) : 1'b1;
            r_c1_almfull   <= (w_state_nxt == ST_RUN) ? (w_c1_cnt_nxt >= c_ALM_THRESH) : 1'b1;
            r_err          <= r_err | w_ovf;
            r_c1_rsp_vld   <= w_c1_pop;
            r_c1_rsp_mdata <= w_c1_pop ? w_c1_mdata : '0;
            // Idle slots carry zeros so the response outputs read 0 when not valid
            r_rd_vld       <= {r_rd_vld[RD_LATENCY-2:0], w_c0_pop};
            r_rd_mdata[0]  <= w_c0_pop ? w_c0_mdata : '0;
            r_rd_data[0]   <= w_c0_pop ? w_rd_data : '0;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_rd_mdata[i] <= r_rd_mdata[i-1];
                r_rd_data[i]  <= r_rd_data[i-1];
            end
        end
    end

    assign bus.c0TxAlmFull  = r_c0_almfull;
    assign bus.c1TxAlmFull  = r_c1_almfull;
    assign bus.c0_rsp_valid = r_rd_vld[RD_LATENCY-1];
    assign bus.c0_rsp_mdata = r_rd_mdata[RD_LATENCY-1];
    assign bus.c0_rsp_data  = r_rd_data[RD_LATENCY-1];
    assign bus.c1_rsp_valid = r_c1_rsp_vld;
    assign bus.c1_rsp_mdata = r_c1_rsp_mdata;
    assign bus.err_overflow = r_err;
    assign bus.init_done    = (r_state == ST_RUN);
endmodule
`default_nettype wire

// File: tb/tb_ccip_host_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ccip_host_mem_responder
// Purpose  : Directed self-checking bench for ccip_host_mem_responder (16-line memory)
// Revision : 1.0  initial release
// ============================================================================
module tb_ccip_host_mem_responder;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   idle_bad = 0;

    typedef struct {
        int           t;
        logic [15:0]  mdata;
        logic [511:0] data;
    } rsp_t;
    rsp_t c0_q[$];
    rsp_t c1_q[$];

    ccip_host_mem_responder_if bus();

    ccip_host_mem_responder #(
        .MEM_ADDR_WIDTH(4),
        .FIFO_DEPTH    (16),
        .ALMFULL_SLACK (8),
        .RD_LATENCY    (4)
    ) dut (
        .pClk                 (clk),
        .pck_cp2af_softReset_n(rst_n),
        .bus                  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Response recorder: cyc is the index of the posedge that launched the value
    always @(negedge clk) begin
        if (bus.c0_rsp_valid) c0_q.push_back('{cyc, bus.c0_rsp_mdata, bus.c0_rsp_data});
        else if (bus.c0_rsp_mdata != '0 || bus.c0_rsp_data != '0) idle_bad++;
        if (bus.c1_rsp_valid) c1_q.push_back('{cyc, bus.c1_rsp_mdata, 512'(0)});
        else if (bus.c1_rsp_mdata != '0) idle_bad++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_req();
        bus.c0_req_valid = 1'b0;
        bus.c0_req_addr  = '0;
        bus.c0_req_mdata = '0;
        bus.c1_req_valid = 1'b0;
        bus.c1_req_addr  = '0;
        bus.c1_req_mdata = '0;
        bus.c1_req_data  = '0;
    endtask

    task automatic do_reset(output int rel);
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        rel = cyc;
    endtask

    task automatic wait_q(input int n, input bit ch);
        for (int i = 0; i < 200; i++) begin
            if ((ch ? c1_q.size() : c0_q.size()) >= n) break;
            tick();
        end
    endtask

    initial begin
        int rel;
        int d;
        logic [511:0] pat_a5;
        logic [511:0] pat_db;
        pat_a5 = {64{8'hA5}};
        pat_db = {16{32'hDEADBEEF}};
        rst_n = 1'b0;
        idle_req();
        tick();
        tick();

        chk("rst_c0almfull", bus.c0TxAlmFull, 1);
        chk("rst_c1almfull", bus.c1TxAlmFull, 1);
        chk("rst_init_done", bus.init_done, 0);
        chk("rst_err", bus.err_overflow, 0);
        chk("rst_c0_valid", bus.c0_rsp_valid, 0);
        chk("rst_c1_valid", bus.c1_rsp_valid, 0);
        chk("rst_c0_data", bus.c0_rsp_data, 0);

        // Release: one sync cycle plus 16 init lines
        rst_n = 1'b1;
        repeat (16) tick();
        chk("init_done_at16", bus.init_done, 0);
        chk("init_almfull_at16", bus.c0TxAlmFull, 1);
        tick();
        chk("init_done_at17", bus.init_done, 1);
        chk("run_c0almfull", bus.c0TxAlmFull, 0);
        chk("run_c1almfull", bus.c1TxAlmFull, 0);

        // Write 0x5 then read it back
        c0_q.delete();
        c1_q.delete();
        d = cyc;
        bus.c1_req_valid = 1'b1;
        bus.c1_req_addr  = 42'h5;
        bus.c1_req_mdata = 16'h0011;
        bus.c1_req_data  = pat_db;
        tick();
        idle_req();
        bus.c0_req_valid = 1'b1;
        bus.c0_req_addr  = 42'h5;
        bus.c0_req_mdata = 16'h0022;
        tick();
        idle_req();
        wait_q(1, 1'b0);
        chk("wr_c1_count", c1_q.size(), 1);
        chk("wr_c1_mdata", c1_q[0].mdata, 16'h0011);
        chk("wr_c1_time", c1_q[0].t, d + 2);
        chk("rd_c0_count", c0_q.size(), 1);
        chk("rd_c0_data", c0_q[0].data, pat_db);
        chk("rd_c0_mdata", c0_q[0].mdata, 16'h0022);
        chk("rd_c0_time", c0_q[0].t, d + 6);

        // Upper address bits alias onto the same line; untouched line reads 0
        c0_q.delete();
        bus.c0_req_valid = 1'b1;
        bus.c0_req_addr  = 42'h200_0000_0015;
        bus.c0_req_mdata = 16'h0023;
        tick();
        bus.c0_req_addr  = 42'h9;
        bus.c0_req_mdata = 16'h0024;
        tick();
        idle_req();
        wait_q(2, 1'b0);
        chk("alias_data", c0_q[0].data, pat_db);
        chk("alias_mdata", c0_q[0].mdata, 16'h0023);
        chk("zero_line_data", c0_q[1].data, 0);
        chk("zero_line_mdata", c0_q[1].mdata, 16'h0024);

        // 16 reads queued during init, drained in order once running
        do_reset(rel);
        c0_q.delete();
        c1_q.delete();
        tick();
        for (int i = 0; i < 16; i++) begin
            bus.c0_req_valid = 1'b1;
            bus.c0_req_addr  = 42'(i);
            bus.c0_req_mdata = 16'(i);
            tick();
        end
        idle_req();
        chk("burst_init_done", bus.init_done, 1);
        chk("burst_almfull_occ16", bus.c0TxAlmFull, 1);
        chk("burst_c1almfull", bus.c1TxAlmFull, 0);
        repeat (8) tick();
        chk("burst_almfull_occ8", bus.c0TxAlmFull, 1);
        tick();
        chk("burst_almfull_occ7", bus.c0TxAlmFull, 0);
        wait_q(16, 1'b0);
        chk("burst_count", c0_q.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("burst_mdata%0d", i), c0_q[i].mdata, 16'(i));
            chk($sformatf("burst_data%0d", i), c0_q[i].data, 0);
        end
        chk("burst_first_time", c0_q[0].t, rel + 21);
        chk("burst_last_time", c0_q[15].t, rel + 36);

        // 17 writes during init: the 17th meets a full FIFO
        do_reset(rel);
        c0_q.delete();
        c1_q.delete();
        tick();
        for (int i = 0; i < 17; i++) begin
            bus.c1_req_valid = 1'b1;
            bus.c1_req_addr  = 42'(i);
            bus.c1_req_mdata = 16'h0100 + 16'(i);
            bus.c1_req_data  = 512'(i + 1);
            tick();
            if (i == 15) chk("ovf_clear_at16", bus.err_overflow, 0);
        end
        idle_req();
        chk("ovf_set", bus.err_overflow, 1);
        wait_q(16, 1'b1);
        repeat (5) tick();
        chk("ovf_c1_count", c1_q.size(), 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("ovf_mdata%0d", i), c1_q[i].mdata, 16'h0100 + 16'(i));
        chk("ovf_sticky", bus.err_overflow, 1);

        // Same-cycle read and write to 0x3: read sees the new data
        c0_q.delete();
        bus.c0_req_valid = 1'b1;
        bus.c0_req_addr  = 42'h3;
        bus.c0_req_mdata = 16'h0033;
        bus.c1_req_valid = 1'b1;
        bus.c1_req_addr  = 42'h3;
        bus.c1_req_mdata = 16'h0044;
        bus.c1_req_data  = pat_a5;
        tick();
        idle_req();
        bus.c0_req_valid = 1'b1;
        bus.c0_req_addr  = 42'h0;
        bus.c0_req_mdata = 16'h0055;
        tick();
        idle_req();
        wait_q(2, 1'b0);
        chk("bypass_data", c0_q[0].data, pat_a5);
        chk("bypass_mdata", c0_q[0].mdata, 16'h0033);
        chk("dropped_not_written", c0_q[1].data, 512'(1));

        // Reset with three reads in flight
        c0_q.delete();
        for (int i = 0; i < 3; i++) begin
            bus.c0_req_valid = 1'b1;
            bus.c0_req_addr  = 42'(i);
            bus.c0_req_mdata = 16'h0060 + 16'(i);
            tick();
        end
        idle_req();
        chk("inflight_none_yet", c0_q.size(), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_c0_valid", bus.c0_rsp_valid, 0);
        chk("midrst_err", bus.err_overflow, 0);
        chk("midrst_init_done", bus.init_done, 0);
        chk("midrst_almfull", bus.c0TxAlmFull, 1);
        repeat (5) tick();
        rst_n = 1'b1;
        repeat (16) tick();
        chk("reinit_done_at16", bus.init_done, 0);
        tick();
        chk("reinit_done_at17", bus.init_done, 1);
        repeat (10) tick();
        chk("midrst_dropped", c0_q.size(), 0);
        chk("idle_outputs_zero", idle_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
